// File: rtl/sync_event_arbiter_if.sv
// Event-arbiter bundle: event pulses and stats clear in, resource handshake and status out.
// The slave side is the arbiter; the master side is the event sources plus the resource.
interface sync_event_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 8
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0] evt_pulse;
  logic             clr_stat;
  logic             done;
  logic             start;
  logic [ID_W-1:0]  grant_id;
  logic             busy;
  logic             timeout;
  logic [N_REQ-1:0] overrun;
  logic [CNT_W-1:0] drop_cnt;

  modport master (
    output evt_pulse, clr_stat, done,
    input  start, grant_id, busy, timeout, overrun, drop_cnt
  );

  modport slave (
    input  evt_pulse, clr_stat, done,
    output start, grant_id, busy, timeout, overrun, drop_cnt
  );
endinterface

// File: rtl/sync_event_arbiter.sv
// Round-robin scheduler sharing one downstream resource between N_REQ event sources,
// with latched pending events, a start/done handshake, a done timeout and overrun stats.
module sync_event_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic                 outclk,
  input  logic                 reset_n,
  sync_event_arbiter_if.slave  bus
);
  localparam int ID_W      = $clog2(N_REQ);
  localparam int TM_W      = $clog2(TIMEOUT_CYC + 1);
  localparam int SUM_W     = $clog2(N_REQ + 1);
  localparam int ACC_W     = ((CNT_W > SUM_W) ? CNT_W : SUM_W) + 1;
  localparam int TM_LAST_I = (TIMEOUT_CYC > 1) ? (TIMEOUT_CYC - 2) : 0;

  localparam logic [1:0]       ST_IDLE  = 2'd0;
  localparam logic [1:0]       ST_ISSUE = 2'd1;
  localparam logic [1:0]       ST_WAIT  = 2'd2;
  localparam logic [ID_W-1:0]  LAST_RST = ID_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [TM_W-1:0]  TM_LAST  = TM_W'(TM_LAST_I);

  logic [1:0]       state_r;
  logic [N_REQ-1:0] pending_r;
  logic [ID_W-1:0]  last_grant_r;
  logic [TM_W-1:0]  timer_r;
  logic [ID_W-1:0]  grant_id_r;
  logic             start_r;
  logic             busy_r;
  logic             timeout_r;
  logic [N_REQ-1:0] overrun_r;
  logic [CNT_W-1:0] drop_cnt_r;

  logic             pick_found_s;
  logic [ID_W-1:0]  pick_s;
  logic [N_REQ-1:0] grant_clr_s;
  logic [N_REQ-1:0] ovr_evt_s;
  logic [SUM_W-1:0] ovr_sum_s;
  logic [ACC_W-1:0] acc_s;
  logic [N_REQ-1:0] overrun_nxt_s;
  logic [CNT_W-1:0] drop_nxt_s;

  // Round-robin pick: first pending requester after last_grant, wrapping around.
  always_comb begin
    logic [ID_W-1:0] idx;
    pick_found_s = 1'b0;
    pick_s       = {ID_W{1'b0}};
    idx          = {ID_W{1'b0}};
    for (int k = 1; k <= N_REQ; k++) begin
      idx          = ID_W'((int'(last_grant_r) + k) % N_REQ);
      pick_s       = (!pick_found_s && pending_r[idx]) ? idx : pick_s;
      pick_found_s = pick_found_s | pending_r[idx];
    end
  end

  // Pending clear mask, overrun detection and saturating drop counter next value.
  always_comb begin
    if ((state_r == ST_IDLE) && pick_found_s) begin
      grant_clr_s = {{(N_REQ-1){1'b0}}, 1'b1} << pick_s;
    end else begin
      grant_clr_s = {N_REQ{1'b0}};
    end
    // The requester being granted this edge may re-pulse without counting as overrun.
    ovr_evt_s = bus.evt_pulse & pending_r & ~grant_clr_s;
    ovr_sum_s = SUM_W'($countones(ovr_evt_s));
    if (bus.clr_stat) begin
      overrun_nxt_s = ovr_evt_s;
      acc_s         = ACC_W'(ovr_sum_s);
    end else begin
      overrun_nxt_s = overrun_r | ovr_evt_s;
      acc_s         = ACC_W'(drop_cnt_r) + ACC_W'(ovr_sum_s);
    end
    if (acc_s > ACC_W'(CNT_MAX)) begin
      drop_nxt_s = CNT_MAX;
    end else begin
      drop_nxt_s = acc_s[CNT_W-1:0];
    end
  end

  // Pending latch and sticky overrun statistics.
  always_ff @(posedge outclk) begin
    if (!reset_n) begin
      pending_r  <= {N_REQ{1'b0}};
      overrun_r  <= {N_REQ{1'b0}};
      drop_cnt_r <= {CNT_W{1'b0}};
    end else begin
      pending_r  <= bus.evt_pulse | (pending_r & ~grant_clr_s);
      overrun_r  <= overrun_nxt_s;
      drop_cnt_r <= drop_nxt_s;
    end
  end

  // Grant FSM with registered start/timeout pulses and busy flag.
  always_ff @(posedge outclk) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      last_grant_r <= LAST_RST;
      timer_r      <= {TM_W{1'b0}};
      grant_id_r   <= {ID_W{1'b0}};
      start_r      <= 1'b0;
      busy_r       <= 1'b0;
      timeout_r    <= 1'b0;
    end else begin
      start_r   <= 1'b0;
      timeout_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (pick_found_s) begin
            grant_id_r <= pick_s;
            start_r    <= 1'b1;
            busy_r     <= 1'b1;
            state_r    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          timer_r <= {TM_W{1'b0}};
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          // done wins over a timeout landing in the same cycle.
          if (bus.done) begin
            last_grant_r <= grant_id_r;
            busy_r       <= 1'b0;
            state_r      <= ST_IDLE;
          end else if (timer_r == TM_LAST) begin
            timeout_r    <= 1'b1;
            last_grant_r <= grant_id_r;
            busy_r       <= 1'b0;
            state_r      <= ST_IDLE;
          end else begin
            timer_r <= timer_r + TM_W'(1);
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.start    = start_r;
  assign bus.grant_id = grant_id_r;
  assign bus.busy     = busy_r;
  assign bus.timeout  = timeout_r;
  assign bus.overrun  = overrun_r;
  assign bus.drop_cnt = drop_cnt_r;
endmodule
